prog_counter: RTL and testbench

Programmable, prescaled up/down counter that replaces the plain free-running counter wherever the game logic needs timed delays, deal/animation pacing or countdowns. Adds a clock prescaler, count direction, runtime load/clear and three terminal behaviours (wrap, one-shot, saturate). It is fully synchronous with one clock domain, and `hitTop` is a registered single-cycle pulse.

---
 rtl/prog_counter.sv | 112 +++++++++++
 tb/tb_prog_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Prescaled up/down counter with runtime load/clear and wrap, one-shot or
// saturate behaviour at the terminal value. All outputs are registered.
module prog_counter #(
    parameter int WIDTH    = 16,
    parameter int PS_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enabled,
    input  logic                clear,
    input  logic                load,
    input  logic [WIDTH-1:0]    loadValue,
    input  logic [WIDTH-1:0]    top,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic                dir,
    input  logic [1:0]          mode,
    output logic [WIDTH-1:0]    value,
    output logic                hitTop,
    output logic                done,
    output logic                step
);

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_SAT     = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    logic [WIDTH-1:0]    value_q, value_d;
    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic                hit_q, hit_d;
    logic                done_q, done_d;
    logic                step_q, step_d;

    logic [WIDTH-1:0]    start_val;
    logic [WIDTH-1:0]    term_val;
    logic [WIDTH-1:0]    load_clamped;
    logic [WIDTH-1:0]    step_val;
    logic                tick;
    logic                hold_term;
    logic                holding_mode;

    always_comb begin
        start_val    = dir ? top : '0;
        term_val     = dir ? '0 : top;
        load_clamped = (loadValue > top) ? top : loadValue;
        // ">=" so that lowering prescale below the running count still fires
        tick         = (ps_q >= prescale);
        holding_mode = (mode == MODE_ONESHOT) || (mode == MODE_SAT);
        hold_term    = holding_mode && (dir ? (value_q == '0) : (value_q >= top));

        if (!dir) begin
            step_val = (value_q >= top) ? '0 : value_q + WIDTH'(1);
        end else begin
            step_val = (value_q == '0) ? top : value_q - WIDTH'(1);
        end

        value_d = value_q;
        ps_d    = ps_q;
        done_d  = done_q;
        hit_d   = 1'b0;
        step_d  = 1'b0;

        if (clear) begin
            value_d = start_val;
            ps_d    = '0;
            done_d  = 1'b0;
        end else if (load) begin
            value_d = load_clamped;
            ps_d    = '0;
            done_d  = 1'b0;
        end else if (enabled && !done_q) begin
            if (tick) begin
                ps_d = '0;
                // Steps at a held terminal are swallowed: no value change, no pulses
                if (!hold_term) begin
                    value_d = step_val;
                    step_d  = 1'b1;
                    hit_d   = (step_val == term_val);
                    if ((mode == MODE_ONESHOT) && (step_val == term_val)) begin
                        done_d = 1'b1;
                    end
                end
            end else begin
                ps_d = ps_q + PS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            ps_q    <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            ps_q    <= ps_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
            step_q  <= step_d;
        end
    end

    assign value  = value_q;
    assign hitTop = hit_q;
    assign done   = done_q;
    assign step   = step_q;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenarios plus random traffic, all checked
// every cycle against an arithmetic reference model.
module tb_prog_counter;

    localparam int WIDTH    = 16;
    localparam int PS_WIDTH = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                enabled;
    logic                clear;
    logic                load;
    logic [WIDTH-1:0]    loadValue;
    logic [WIDTH-1:0]    top;
    logic [PS_WIDTH-1:0] prescale;
    logic                dir;
    logic [1:0]          mode;
    logic [WIDTH-1:0]    value;
    logic                hitTop;
    logic                done;
    logic                step;

    prog_counter #(.WIDTH(WIDTH), .PS_WIDTH(PS_WIDTH)) dut (
        .clk(clk), .reset(reset), .enabled(enabled), .clear(clear), .load(load),
        .loadValue(loadValue), .top(top), .prescale(prescale), .dir(dir), .mode(mode),
        .value(value), .hitTop(hitTop), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int m_val, m_ps;
    bit m_done, m_hit, m_step;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of the counter as described behaviourally, on plain integers.
    task automatic model_step();
        int t, nxt, term;
        bit frozen_at_end;
        t     = int'(top);
        term  = dir ? 0 : t;
        m_hit  = 0;
        m_step = 0;
        if (reset) begin
            m_val = 0; m_ps = 0; m_done = 0;
        end else if (clear) begin
            m_val = dir ? t : 0; m_ps = 0; m_done = 0;
        end else if (load) begin
            m_val = (int'(loadValue) < t) ? int'(loadValue) : t;
            m_ps = 0; m_done = 0;
        end else if (enabled && !m_done) begin
            if (m_ps < int'(prescale)) begin
                m_ps = m_ps + 1;
            end else begin
                m_ps = 0;
                frozen_at_end = (mode == 2'b01 || mode == 2'b10) &&
                                (dir ? (m_val == 0) : (m_val >= t));
                if (!frozen_at_end) begin
                    if (!dir) nxt = (m_val > t) ? 0 : (m_val + 1) % (t + 1);
                    else      nxt = (m_val == 0) ? t : m_val - 1;
                    m_val  = nxt;
                    m_step = 1;
                    m_hit  = (nxt == term);
                    if (mode == 2'b01 && m_hit) m_done = 1;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("value",  value,  m_val);
        chk("hitTop", hitTop, m_hit);
        chk("step",   step,   m_step);
        chk("done",   done,   m_done);
    endtask

    initial begin
        reset = 1; enabled = 1; clear = 0; load = 0; loadValue = 0;
        top = 3; prescale = 0; dir = 0; mode = 2'b00;
        m_val = 0; m_ps = 0; m_done = 0; m_hit = 0; m_step = 0;
        @(negedge clk);
        cyc();
        chk("reset_value", value, 0);
        chk("reset_pulses", {hitTop, step, done}, 0);
        reset = 0;

        // Wrap up, top=3, prescale=0
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk("wrap_value", value, i % 4);
            chk("wrap_hit", hitTop, (i % 4) == 3);
            chk("wrap_step", step, 1);
        end

        // Prescaled one-shot down count
        prescale = 2; top = 2; dir = 1; mode = 2'b01; clear = 1;
        cyc();
        clear = 0;
        chk("os_clear", value, 2);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("os_value", value, (k <= 2) ? 2 : (k <= 5) ? 1 : 0);
            chk("os_hit", hitTop, k == 6);
        end
        chk("os_done", done, 1);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("os_hold", {value, hitTop, step, done}, {16'd0, 3'b001});
        end
        clear = 1;
        cyc();
        clear = 0;
        chk("os_restart", {value, done}, {16'd2, 1'b0});

        // Saturate up then down
        top = 5; mode = 2'b10; dir = 0; prescale = 0; clear = 1;
        cyc();
        clear = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("sat_up", value, k);
            chk("sat_up_hit", hitTop, k == 5);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("sat_hold", {value, hitTop, step}, {16'd5, 2'b00});
        end
        dir = 1;
        for (int k = 4; k >= 0; k--) begin
            cyc();
            chk("sat_down", value, k);
            chk("sat_down_hit", hitTop, k == 0);
        end

        // Priority and clamping
        top = 6; load = 1; loadValue = 9; mode = 2'b00;
        cyc();
        chk("load_clamp", {value, hitTop, step}, {16'd6, 2'b00});
        dir = 0; clear = 1;
        cyc();
        chk("clear_over_load", value, 0);
        reset = 1; enabled = 1; dir = 1;
        cyc();
        chk("reset_all", {value, hitTop, step, done}, 0);
        reset = 0; load = 0; clear = 0;

        // Freeze mid-prescale
        dir = 0; mode = 2'b00; top = 100; prescale = 3; clear = 1;
        cyc();
        clear = 0;
        cyc(); cyc();
        enabled = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("freeze", {value, step}, {16'd0, 1'b0});
        end
        enabled = 1;
        cyc();
        chk("resume_wait", step, 0);
        cyc();
        chk("resume_step", {value, step}, {16'd1, 1'b1});

        // Runtime top change
        prescale = 0; load = 1; loadValue = 8;
        cyc();
        load = 0;
        chk("rt_load", value, 8);
        top = 4;
        cyc();
        chk("rt_wrap", {value, hitTop, step}, {16'd0, 2'b01});
        top = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("top0", {value, hitTop, step}, {16'd0, 2'b11});
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            reset   = (r == 0);
            clear   = (r >= 1 && r <= 4);
            load    = (r >= 5 && r <= 9);
            enabled = ($urandom_range(0, 9) != 0);
            loadValue = WIDTH'($urandom_range(0, 9));
            if ($urandom_range(0, 29) == 0) top      = WIDTH'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) prescale = PS_WIDTH'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) dir      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) mode     = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
